// File: rtl/video_stream_gen.sv
// Test video source: programmable frame timing, sparse pixel cadence
// and four selectable test patterns on a registered do/de/hs/vs stream.
module video_stream_gen #(
  parameter int PIXEL_WIDTH = 12,
  parameter int SPARSE      = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic [15:0]            reg_h_act,
  input  logic [15:0]            reg_h_blank,
  input  logic [15:0]            reg_v_act,
  input  logic [15:0]            reg_v_blank,
  input  logic [1:0]             reg_pattern,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o,
  output logic                   busy_o,
  output logic [15:0]            frame_cnt_o
);

  localparam logic [15:0] PH_LAST = 16'(SPARSE);

  typedef enum logic [1:0] {
    IDLE,
    ACT,
    HBLANK,
    VACT
  } state_t;

  state_t state_q, state_d;

  logic [15:0] x_q, x_d;
  logic [15:0] ph_q, ph_d;
  logic [15:0] b_q, b_d;
  logic [16:0] y_q, y_d;
  logic [15:0] fc_q, fc_d;

  logic [15:0] ha_q, ha_d;
  logic [15:0] hb_q, hb_d;
  logic [15:0] va_q, va_d;
  logic [15:0] vb_q, vb_d;
  logic [1:0]  pat_q, pat_d;

  logic [PIXEL_WIDTH-1:0] do_q, do_d;
  logic de_q, de_d;
  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic busy_q, busy_d;

  logic                   start_ok;
  logic                   load;
  logic                   last_line;
  logic                   act_line;
  logic [16:0]            lines;
  logic [PIXEL_WIDTH-1:0] pix;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    ph_d    = ph_q;
    b_d     = b_q;
    y_d     = y_q;
    fc_d    = fc_q;
    ha_d    = ha_q;
    hb_d    = hb_q;
    va_d    = va_q;
    vb_d    = vb_q;
    pat_d   = pat_q;
    load    = 1'b0;
    pix     = '0;

    start_ok  = en_i && (reg_h_act != 16'd0)
                && (reg_v_act != 16'd0);
    lines     = {1'b0, va_q} + {1'b0, vb_q};
    last_line = (y_q == lines - 17'd1);
    act_line  = (y_q < {1'b0, va_q});

    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = ACT;
          load    = 1'b1;
        end
      end
      ACT, VACT: begin
        if (ph_q == PH_LAST) begin
          ph_d = 16'd0;
          if (x_q == ha_q - 16'd1) begin
            x_d     = 16'd0;
            b_d     = 16'd0;
            state_d = HBLANK;
          end else begin
            x_d = x_q + 16'd1;
          end
        end else begin
          ph_d = ph_q + 16'd1;
        end
      end
      HBLANK: begin
        if (b_q == hb_q - 16'd1) begin
          b_d = 16'd0;
          if (last_line) begin
            fc_d = fc_q + 16'd1;
            if (start_ok) begin
              state_d = ACT;
              load    = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            y_d = y_q + 17'd1;
            if (y_q + 17'd1 < {1'b0, va_q})
              state_d = ACT;
            else
              state_d = VACT;
          end
        end else begin
          b_d = b_q + 16'd1;
        end
      end
    endcase

    // Zero blanking is widened to one so hs/vs are always visible.
    if (load) begin
      ha_d  = reg_h_act;
      hb_d  = (reg_h_blank == 16'd0) ? 16'd1 : reg_h_blank;
      va_d  = reg_v_act;
      vb_d  = (reg_v_blank == 16'd0) ? 16'd1 : reg_v_blank;
      pat_d = reg_pattern;
      x_d   = 16'd0;
      ph_d  = 16'd0;
      b_d   = 16'd0;
      y_d   = 17'd0;
    end

    unique case (pat_q)
      2'd0: pix = PIXEL_WIDTH'(x_q);
      2'd1: pix = PIXEL_WIDTH'(y_q);
      2'd2: pix = {PIXEL_WIDTH{x_q[3] ^ y_q[3]}};
      2'd3: pix = PIXEL_WIDTH'(x_q + fc_q);
    endcase

    de_d   = (state_q == ACT) && (ph_q == 16'd0);
    do_d   = de_d ? pix : '0;
    hs_d   = (state_q == HBLANK);
    vs_d   = (state_q == VACT)
             || ((state_q == HBLANK) && !act_line);
    busy_d = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      ph_q    <= '0;
      b_q     <= '0;
      y_q     <= '0;
      fc_q    <= '0;
      ha_q    <= '0;
      hb_q    <= '0;
      va_q    <= '0;
      vb_q    <= '0;
      pat_q   <= '0;
      do_q    <= '0;
      de_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      ph_q    <= ph_d;
      b_q     <= b_d;
      y_q     <= y_d;
      fc_q    <= fc_d;
      ha_q    <= ha_d;
      hb_q    <= hb_d;
      va_q    <= va_d;
      vb_q    <= vb_d;
      pat_q   <= pat_d;
      do_q    <= do_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      busy_q  <= busy_d;
    end
  end

  assign do_o        = do_q;
  assign de_o        = de_q;
  assign hs_o        = hs_q;
  assign vs_o        = vs_q;
  assign busy_o      = busy_q;
  assign frame_cnt_o = fc_q;

endmodule

// File: tb/tb_video_stream_gen.sv
// Bench for video_stream_gen: dense and sparse instances checked
// cycle by cycle against a frame-level reference stream.
module tb_video_stream_gen;

  localparam int PW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en0 = 1'b0;
  logic en2 = 1'b0;
  logic [15:0] r_ha = '0;
  logic [15:0] r_hb = '0;
  logic [15:0] r_va = '0;
  logic [15:0] r_vb = '0;
  logic [1:0]  r_pat = '0;

  logic [PW-1:0] do0, do2;
  logic de0, hs0, vs0, busy0;
  logic de2, hs2, vs2, busy2;
  logic [15:0] fcnt0, fcnt2;

  always #5 clk = ~clk;

  video_stream_gen #(.PIXEL_WIDTH(PW), .SPARSE(0)) dut0 (
    .clk(clk), .rst(rst), .en_i(en0),
    .reg_h_act(r_ha), .reg_h_blank(r_hb),
    .reg_v_act(r_va), .reg_v_blank(r_vb),
    .reg_pattern(r_pat),
    .do_o(do0), .de_o(de0), .hs_o(hs0), .vs_o(vs0),
    .busy_o(busy0), .frame_cnt_o(fcnt0)
  );

  video_stream_gen #(.PIXEL_WIDTH(PW), .SPARSE(2)) dut2 (
    .clk(clk), .rst(rst), .en_i(en2),
    .reg_h_act(r_ha), .reg_h_blank(r_hb),
    .reg_v_act(r_va), .reg_v_blank(r_vb),
    .reg_pattern(r_pat),
    .do_o(do2), .de_o(de2), .hs_o(hs2), .vs_o(vs2),
    .busy_o(busy2), .frame_cnt_o(fcnt2)
  );

  typedef struct packed {
    logic          de;
    logic [PW-1:0] pix;
    logic          hs;
    logic          vs;
    logic [15:0]   fc;
  } exp_t;

  typedef struct {
    int ha;
    int hb;
    int va;
    int vb;
    int pat;
  } cfg_t;

  exp_t q0[$];
  exp_t q2[$];
  int checks = 0;
  int errors = 0;
  int mfc0 = 0;
  int mfc2 = 0;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, a, e);
    end
  endtask

  function automatic int flen(input cfg_t c, input int s);
    int hb, vb;
    hb = (c.hb == 0) ? 1 : c.hb;
    vb = (c.vb == 0) ? 1 : c.vb;
    return (c.ha * (s + 1) + hb) * (c.va + vb);
  endfunction

  function automatic logic [PW-1:0] pix_of(input int pat, input int x,
                                           input int y, input int f);
    int v;
    case (pat)
      0: v = x;
      1: v = y;
      2: v = (((x >> 3) ^ (y >> 3)) & 1) != 0 ? -1 : 0;
      default: v = x + f;
    endcase
    return v[PW-1:0];
  endfunction

  // Expected stream of one frame, one entry per output cycle.
  task automatic push_frame(input cfg_t c, input int s, input int d);
    int f, total, idx, hb, vb;
    bit act;
    exp_t e;
    f = (d == 0) ? mfc0 : mfc2;
    hb = (c.hb == 0) ? 1 : c.hb;
    vb = (c.vb == 0) ? 1 : c.vb;
    total = flen(c, s);
    idx = 0;
    for (int ln = 0; ln < c.va + vb; ln++) begin
      act = (ln < c.va);
      for (int x = 0; x < c.ha; x++) begin
        for (int p = 0; p <= s; p++) begin
          e.de  = act && (p == 0);
          e.pix = e.de ? pix_of(c.pat, x, ln, f) : '0;
          e.hs  = 1'b0;
          e.vs  = !act;
          e.fc  = 16'(idx == total - 1 ? f + 1 : f);
          if (d == 0) q0.push_back(e); else q2.push_back(e);
          idx++;
        end
      end
      for (int b = 0; b < hb; b++) begin
        e.de  = 1'b0;
        e.pix = '0;
        e.hs  = 1'b1;
        e.vs  = !act;
        e.fc  = 16'(idx == total - 1 ? f + 1 : f);
        if (d == 0) q0.push_back(e); else q2.push_back(e);
        idx++;
      end
    end
    if (d == 0) mfc0 = (f + 1) & 16'hFFFF;
    else        mfc2 = (f + 1) & 16'hFFFF;
  endtask

  always @(negedge clk) begin
    exp_t a, e;
    a = {de0, do0, hs0, vs0, fcnt0};
    if (busy0) begin
      if (q0.size() == 0) begin
        chk("dut0_extra_cycle", 64'(a), 64'hDEAD);
      end else begin
        e = q0.pop_front();
        chk("dut0_stream", 64'(a), 64'(e));
      end
    end else begin
      chk("dut0_idle_out", {de0, do0, hs0, vs0}, 64'd0);
    end
  end

  always @(negedge clk) begin
    exp_t a, e;
    a = {de2, do2, hs2, vs2, fcnt2};
    if (busy2) begin
      if (q2.size() == 0) begin
        chk("dut2_extra_cycle", 64'(a), 64'hDEAD);
      end else begin
        e = q2.pop_front();
        chk("dut2_stream", 64'(a), 64'(e));
      end
    end else begin
      chk("dut2_idle_out", {de2, do2, hs2, vs2}, 64'd0);
    end
  end

  task automatic set_regs(input cfg_t c);
    r_ha  = 16'(c.ha);
    r_hb  = 16'(c.hb);
    r_va  = 16'(c.va);
    r_vb  = 16'(c.vb);
    r_pat = 2'(c.pat);
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (n < bound && !(q0.size() == 0 && q2.size() == 0
                          && !busy0 && !busy2)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= bound) begin
      errors++;
      $display("FAIL wait_done: got %0d/%0d left, required 0/0",
               q0.size(), q2.size());
      q0.delete();
      q2.delete();
    end
  endtask

  task automatic run_both(input cfg_t c);
    @(posedge clk);
    #1;
    set_regs(c);
    en0 = 1'b1;
    en2 = 1'b1;
    push_frame(c, 0, 0);
    push_frame(c, 2, 2);
    @(posedge clk);
    #1;
    en0 = 1'b0;
    en2 = 1'b0;
    wait_done(4000);
  endtask

  // n frames on dut0: first uses c1, the rest c2 (regs switched at chg).
  task automatic run_frames(input cfg_t c1, input cfg_t c2, input int n,
                            input int chg, input int extra);
    int d;
    @(posedge clk);
    #1;
    set_regs(c1);
    en0 = 1'b1;
    push_frame(c1, 0, 0);
    for (int i = 1; i < n; i++) push_frame(c2, 0, 0);
    @(posedge clk);
    #1;
    d = (n == 1) ? extra : flen(c1, 0) + (n - 2) * flen(c2, 0) + 1;
    for (int t = 1; t <= d; t++) begin
      @(posedge clk);
      #1;
      if (t == chg) set_regs(c2);
    end
    en0 = 1'b0;
    wait_done(4000);
  endtask

  initial begin
    cfg_t c, c2;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_state0", {de0, do0, hs0, vs0, busy0, fcnt0}, 64'd0);
    chk("reset_state2", {de2, do2, hs2, vs2, busy2, fcnt2}, 64'd0);

    run_both('{4, 2, 2, 1, 0});
    chk("basic_fcnt0", 64'(fcnt0), 64'd1);
    run_both('{3, 1, 2, 1, 2});

    // Reset two cycles into an active line.
    c = '{6, 2, 2, 1, 0};
    @(posedge clk);
    #1;
    set_regs(c);
    en0 = 1'b1;
    push_frame(c, 0, 0);
    @(posedge clk);
    #1;
    en0 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q0.delete();
    q2.delete();
    mfc0 = 0;
    mfc2 = 0;
    chk("rst_mid_outputs", {de0, do0, hs0, vs0, busy0}, 64'd0);
    chk("rst_mid_fcnt", 64'(fcnt0), 64'd0);

    c = '{5, 2, 2, 1, 3};
    run_frames(c, c, 3, 0, 0);
    chk("cont_fcnt", 64'(fcnt0), 64'd3);

    run_frames('{4, 2, 2, 1, 0}, '{8, 2, 2, 1, 0}, 2, 3, 0);

    @(posedge clk);
    #1;
    set_regs('{0, 2, 2, 1, 0});
    en0 = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("hact0_busy", 64'(busy0), 64'd0);
    end
    set_regs('{4, 2, 0, 1, 0});
    repeat (3) begin
      @(negedge clk);
      chk("vact0_busy", 64'(busy0), 64'd0);
    end
    en0 = 1'b0;

    run_both('{4, 0, 2, 0, 1});

    c = '{6, 2, 3, 1, 2};
    run_frames(c, c, 1, 0, 3);
    chk("endrop_busy", 64'(busy0), 64'd0);

    for (int i = 0; i < 6; i++) begin
      c.ha  = $urandom_range(1, 20);
      c.hb  = $urandom_range(0, 4);
      c.va  = $urandom_range(1, 5);
      c.vb  = $urandom_range(0, 3);
      c.pat = $urandom_range(0, 3);
      run_both(c);
    end
    c2.ha  = $urandom_range(1, 20);
    c2.hb  = $urandom_range(0, 4);
    c2.va  = $urandom_range(1, 5);
    c2.vb  = $urandom_range(0, 3);
    c2.pat = $urandom_range(0, 3);
    run_frames(c, c2, 3, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
